// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that locks one of four requesters onto the FIFO write port until its last beat.
// Latency: one IDLE arbitration cycle per burst, then data passes combinationally; backpressure: i_fifo_full drops the owner's ready.
// Optional FIFO-full stall counter is built only when FIFO_WR_ARB_STALLCNT_EN is defined.
module fifo_wr_arb #(
    parameter int P_WIDTH = 8
) (
    input  logic                   i_wrclk,
    input  logic                   i_wrrstn,
    input  logic [3:0]             i_req_valid,
    input  logic [4*P_WIDTH-1:0]   i_req_data,
    input  logic [3:0]             i_req_last,
    output logic [3:0]             o_req_ready,
    input  logic                   i_fifo_full,
    output logic                   o_fifo_wren,
    output logic [P_WIDTH-1:0]     o_fifo_wrdata,
    output logic [3:0]             o_grant,
    output logic                   o_busy,
    input  logic                   i_stall_clr,
    output logic [15:0]            o_stall_cnt
);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] owner;
    logic [1:0] pick;
    logic       owner_vld;
    logic       owner_last;
    logic       xfer;

    // Walk downward so the requester closest above rr_ptr is the last one written.
    always_comb begin
        pick = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (i_req_valid[rr_ptr + 2'(i)]) begin
                pick = rr_ptr + 2'(i);
            end
        end
    end

    assign owner_vld     = i_req_valid[owner];
    assign owner_last    = i_req_last[owner];
    assign xfer          = o_busy & owner_vld & ~i_fifo_full;

    assign o_req_ready   = o_grant & {4{o_busy & ~i_fifo_full}};
    assign o_fifo_wren   = xfer;
    assign o_fifo_wrdata = o_busy ? i_req_data[owner*P_WIDTH +: P_WIDTH] : '0;

    always_ff @(posedge i_wrclk or negedge i_wrrstn) begin
        if (!i_wrrstn) begin
            state   <= ST_IDLE;
            rr_ptr  <= 2'd0;
            owner   <= 2'd0;
            o_grant <= 4'd0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|i_req_valid) begin
                        state   <= ST_LOCK;
                        owner   <= pick;
                        o_grant <= 4'b0001 << pick;
                        o_busy  <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    // Owner keeps the port through valid gaps; only its last beat releases it.
                    if (xfer && owner_last) begin
                        state   <= ST_IDLE;
                        o_grant <= 4'd0;
                        o_busy  <= 1'b0;
                        rr_ptr  <= owner + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALLCNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_wrclk or negedge i_wrrstn) begin
        if (!i_wrrstn) begin
            stall_q <= 16'd0;
        end else if (i_stall_clr) begin
            stall_q <= 16'd0;
        end else if (o_busy && owner_vld && i_fifo_full && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = i_stall_clr;
    assign o_stall_cnt      = 16'd0;
`endif

endmodule
